// File: rtl/mem_stage.sv
// Memory-access stage of the Beta pipeline: issues LD/LDR/ST to data memory over a
// valid/ready request with an rvalid response, stalls upstream while an access is
// outstanding, and registers {pc, id, y, MRD} into WB (bubbles when nothing completes).
module mem_stage #(
    parameter logic [31:0] BUBBLE = 32'h83FFF800,
    parameter logic [5:0]  OP_LD  = 6'b011000,
    parameter logic [5:0]  OP_LDR = 6'b011111,
    parameter logic [5:0]  OP_ST  = 6'b011001
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] pc_MEM,
    input  logic [31:0] id_MEM,
    input  logic [31:0] y_MEM,
    input  logic [31:0] sd_MEM,
    output logic        stall_MEM,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic [31:0] pc_WB,
    output logic [31:0] id_WB,
    output logic [31:0] y_WB,
    output logic [31:0] MRD,
    output logic        misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

    state_e      state_q, state_d;
    logic [5:0]  opcode;
    logic        is_ld, is_st, memop, aligned;
    logic        done, ld_done, req_raw;
    logic [31:0] pc_q, id_q, y_q, mrd_q;
    logic        misalign_q;

    assign opcode  = id_MEM[31:26];
    assign is_ld   = (opcode == OP_LD) || (opcode == OP_LDR);
    assign is_st   = (opcode == OP_ST);
    assign memop   = is_ld || is_st;
    assign aligned = (y_MEM[1:0] == 2'b00);

    // Access FSM: decides request, completion and next state for the op held in MEM.
    always_comb begin
        state_d = state_q;
        req_raw = 1'b0;
        done    = 1'b0;
        ld_done = 1'b0;
        if (!memop || !aligned) begin
            // Pass-through ops and misaligned memops finish immediately with no access.
            done    = 1'b1;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StReq: begin
                    req_raw = 1'b1;
                    if (dm_ready) begin
                        if (is_st) begin
                            done    = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StWaitR;
                        end
                    end else begin
                        state_d = StReq;
                    end
                end
                StWaitR: begin
                    // dm_ready is deliberately ignored here: only one access outstanding.
                    if (dm_rvalid) begin
                        done    = 1'b1;
                        ld_done = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Reset forces the handshake quiet even before the first clock edge.
    assign dm_req    = req_raw && n_rst;
    assign stall_MEM = memop && !done && n_rst;
    assign dm_we     = is_st;
    assign dm_addr   = y_MEM;
    assign dm_wdata  = sd_MEM;

    // State register and WB pipeline register; bubble on every edge where nothing completes.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            pc_q       <= 32'h0;
            id_q       <= BUBBLE;
            y_q        <= 32'h0;
            mrd_q      <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (done) begin
                pc_q       <= pc_MEM;
                id_q       <= id_MEM;
                y_q        <= y_MEM;
                mrd_q      <= ld_done ? dm_rdata : 32'h0;
                misalign_q <= memop && !aligned;
            end else begin
                pc_q       <= 32'h0;
                id_q       <= BUBBLE;
                y_q        <= 32'h0;
                mrd_q      <= 32'h0;
                misalign_q <= 1'b0;
            end
        end
    end

    assign pc_WB    = pc_q;
    assign id_WB    = id_q;
    assign y_WB     = y_q;
    assign MRD      = mrd_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    localparam logic [31:0] BUBBLE = 32'h83FFF800;
    localparam logic [31:0] I_ADD  = 32'h80221800;
    localparam logic [31:0] I_LD   = 32'h60000000;
    localparam logic [31:0] I_ST   = 32'h64000000;

    logic        clk;
    logic        n_rst;
    logic [31:0] pc_MEM, id_MEM, y_MEM, sd_MEM;
    logic        stall_MEM, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ready, dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] pc_WB, id_WB, y_WB, MRD;
    logic        misalign;

    int checks;
    int failures;

    mem_stage dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .pc_MEM   (pc_MEM),
        .id_MEM   (id_MEM),
        .y_MEM    (y_MEM),
        .sd_MEM   (sd_MEM),
        .stall_MEM(stall_MEM),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ready (dm_ready),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .pc_WB    (pc_WB),
        .id_WB    (id_WB),
        .y_WB     (y_WB),
        .MRD      (MRD),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_rst     = 1'b0;
        pc_MEM    = 32'h0;
        id_MEM    = I_LD;
        y_MEM     = 32'h100;
        sd_MEM    = 32'h0;
        dm_ready  = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = 32'h0;

        // 1: reset held two cycles with an LD in MEM
        #1;
        check("rst_req_pre", {31'b0, dm_req}, 32'd0);
        check("rst_stall_pre", {31'b0, stall_MEM}, 32'd0);
        step();
        step();
        check("rst_id", id_WB, BUBBLE);
        check("rst_pc", pc_WB, 32'h0);
        check("rst_mrd", MRD, 32'h0);
        check("rst_req", {31'b0, dm_req}, 32'd0);
        check("rst_stall", {31'b0, stall_MEM}, 32'd0);

        // 2: ADD passes through in one cycle
        n_rst  = 1'b1;
        id_MEM = I_ADD;
        pc_MEM = 32'h10;
        y_MEM  = 32'h5;
        #1;
        check("add_stall", {31'b0, stall_MEM}, 32'd0);
        check("add_req", {31'b0, dm_req}, 32'd0);
        step();
        check("add_id", id_WB, I_ADD);
        check("add_y", y_WB, 32'h5);
        check("add_pc", pc_WB, 32'h10);
        check("add_mrd", MRD, 32'h0);

        // 3: LD accepted in cycle 0, rvalid in cycle 2
        id_MEM   = I_LD;
        pc_MEM   = 32'h20;
        y_MEM    = 32'h100;
        dm_ready = 1'b1;
        #1;
        check("ld_req0", {31'b0, dm_req}, 32'd1);
        check("ld_we0", {31'b0, dm_we}, 32'd0);
        check("ld_addr0", dm_addr, 32'h100);
        check("ld_stall0", {31'b0, stall_MEM}, 32'd1);
        step();
        check("ld_bub0", id_WB, BUBBLE);
        dm_ready = 1'b0;
        #1;
        check("ld_req1", {31'b0, dm_req}, 32'd0);
        check("ld_stall1", {31'b0, stall_MEM}, 32'd1);
        step();
        check("ld_bub1", id_WB, BUBBLE);
        dm_rvalid = 1'b1;
        dm_rdata  = 32'hDEADBEEF;
        #1;
        check("ld_stall2", {31'b0, stall_MEM}, 32'd0);
        step();
        check("ld_mrd", MRD, 32'hDEADBEEF);
        check("ld_id", id_WB, I_LD);
        check("ld_pc", pc_WB, 32'h20);
        check("ld_y", y_WB, 32'h100);
        dm_rvalid = 1'b0;

        // 4: ST with dm_ready low for three cycles
        id_MEM = I_ST;
        pc_MEM = 32'h24;
        y_MEM  = 32'h200;
        sd_MEM = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_req_w", {31'b0, dm_req}, 32'd1);
            check("st_we_w", {31'b0, dm_we}, 32'd1);
            check("st_addr_w", dm_addr, 32'h200);
            check("st_wdata_w", dm_wdata, 32'h55);
            check("st_stall_w", {31'b0, stall_MEM}, 32'd1);
            step();
            check("st_bub", id_WB, BUBBLE);
        end
        dm_ready = 1'b1;
        #1;
        check("st_req_acc", {31'b0, dm_req}, 32'd1);
        check("st_addr_acc", dm_addr, 32'h200);
        check("st_stall_acc", {31'b0, stall_MEM}, 32'd0);
        step();
        check("st_id", id_WB, I_ST);
        check("st_pc", pc_WB, 32'h24);
        check("st_mrd", MRD, 32'h0);
        dm_ready = 1'b0;

        // 5: misaligned LD
        id_MEM   = I_LD;
        pc_MEM   = 32'h28;
        y_MEM    = 32'h102;
        dm_rdata = 32'hCAFEF00D;
        #1;
        check("mis_req", {31'b0, dm_req}, 32'd0);
        check("mis_stall", {31'b0, stall_MEM}, 32'd0);
        step();
        check("mis_pulse", {31'b0, misalign}, 32'd1);
        check("mis_mrd", MRD, 32'h0);
        check("mis_id", id_WB, I_LD);
        check("mis_y", y_WB, 32'h102);
        id_MEM = I_ADD;
        y_MEM  = 32'h7;
        step();
        check("mis_clear", {31'b0, misalign}, 32'd0);

        // 6: reset during WAIT_R, then stray rvalid
        id_MEM   = I_LD;
        pc_MEM   = 32'h30;
        y_MEM    = 32'h300;
        dm_ready = 1'b1;
        step();
        dm_ready = 1'b0;
        #1;
        check("wr_stall", {31'b0, stall_MEM}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("wr_rst_req", {31'b0, dm_req}, 32'd0);
        check("wr_rst_stall", {31'b0, stall_MEM}, 32'd0);
        step();
        check("wr_rst_id", id_WB, BUBBLE);
        // Back in IDLE: stray rvalid must not complete the LD; a new request is raised instead.
        n_rst     = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h12345678;
        #1;
        check("stray_req", {31'b0, dm_req}, 32'd1);
        check("stray_stall", {31'b0, stall_MEM}, 32'd1);
        step();
        check("stray_id", id_WB, BUBBLE);
        check("stray_mrd", MRD, 32'h0);
        // Stray rvalid with a pass-through op in IDLE
        id_MEM = I_ADD;
        pc_MEM = 32'h34;
        y_MEM  = 32'h9;
        step();
        check("stray_add_id", id_WB, I_ADD);
        check("stray_add_mrd", MRD, 32'h0);
        dm_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
